// File: rtl/alu_if.sv
// ALU request/response bus: the master drives operands and the strobe, and the
// slave (the ALU engine) returns the result, flags and ready.
interface alu_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 5,
    parameter int unsigned STAT_W = 5
);
    logic              alu_enable;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_out;
    logic [STAT_W-1:0] alu_status;
    logic              alu_ready;

    modport master (
        output alu_enable,
        output alu_in1,
        output alu_in2,
        output alu_op,
        input  alu_out,
        input  alu_status,
        input  alu_ready
    );

    modport slave (
        input  alu_enable,
        input  alu_in1,
        input  alu_in2,
        input  alu_op,
        output alu_out,
        output alu_status,
        output alu_ready
    );
endinterface

// File: rtl/alu_core.sv
// 8-bit ALU engine on an enable/ready handshake. Simple ops finish one cycle
// after acceptance; multiply/divide/modulo iterate for eight cycles.
// Status word: [0] carry, [1] zero, [2] negative, [3] overflow, [4] error.
module alu_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 5,
    parameter int unsigned STAT_W = 5
) (
    input logic  clk,
    input logic  reset_n,
    alu_if.slave alu_bus
);

    localparam int unsigned ProdW = 2 * DATA_W;

    localparam logic [OP_W-1:0] OpAdd  = OP_W'(0);
    localparam logic [OP_W-1:0] OpSub  = OP_W'(1);
    localparam logic [OP_W-1:0] OpAnd  = OP_W'(2);
    localparam logic [OP_W-1:0] OpOr   = OP_W'(3);
    localparam logic [OP_W-1:0] OpXor  = OP_W'(4);
    localparam logic [OP_W-1:0] OpNot  = OP_W'(5);
    localparam logic [OP_W-1:0] OpShl  = OP_W'(6);
    localparam logic [OP_W-1:0] OpShr  = OP_W'(7);
    localparam logic [OP_W-1:0] OpRol  = OP_W'(8);
    localparam logic [OP_W-1:0] OpRor  = OP_W'(9);
    localparam logic [OP_W-1:0] OpInc  = OP_W'(10);
    localparam logic [OP_W-1:0] OpDec  = OP_W'(11);
    localparam logic [OP_W-1:0] OpCmp  = OP_W'(12);
    localparam logic [OP_W-1:0] OpMull = OP_W'(13);
    localparam logic [OP_W-1:0] OpMulh = OP_W'(14);
    localparam logic [OP_W-1:0] OpDiv  = OP_W'(15);
    localparam logic [OP_W-1:0] OpMod  = OP_W'(16);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StIter
    } state_e;

    state_e            state_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        cnt_q;
    logic [ProdW-1:0]  prod_q;
    logic [ProdW-1:0]  mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] out_q;
    logic [STAT_W-1:0] status_q;
    logic              ready_q;

    assign alu_bus.alu_out    = out_q;
    assign alu_bus.alu_status = status_q;
    assign alu_bus.alu_ready  = ready_q;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [DATA_W:0]   sum9;
    logic [DATA_W:0]   dif9;
    logic [DATA_W:0]   inc9;
    logic [DATA_W:0]   dec9;
    logic [DATA_W:0]   shl9;
    logic [DATA_W:0]   shr9;
    logic [2:0]        shamt;
    logic [2:0]        shamt_neg;
    logic [DATA_W-1:0] exec_res;
    logic [DATA_W-1:0] flag_src;
    logic              exec_c;
    logic              exec_v;
    logic              exec_err;
    logic [STAT_W-1:0] exec_stat;

    // Result and flags for ops completing on the EXEC path (incl. illegal, div-by-0)
    always_comb begin
        shamt     = b_q[2:0];
        shamt_neg = 3'd0 - shamt;
        sum9      = {1'b0, a_q} + {1'b0, b_q};
        dif9      = {1'b0, a_q} - {1'b0, b_q};
        inc9      = {1'b0, a_q} + 9'd1;
        dec9      = {1'b0, a_q} - 9'd1;
        // Extra bit catches the last bit shifted out (zero when shamt == 0)
        shl9      = {1'b0, a_q} << shamt;
        shr9      = {a_q, 1'b0} >> shamt;

        exec_res  = '0;
        exec_c    = 1'b0;
        exec_v    = 1'b0;
        exec_err  = 1'b0;

        case (op_q)
            OpAdd: begin
                exec_res = sum9[DATA_W-1:0];
                exec_c   = sum9[DATA_W];
                exec_v   = (a_q[7] == b_q[7]) && (sum9[7] != a_q[7]);
            end
            OpSub, OpCmp: begin
                exec_res = dif9[DATA_W-1:0];
                exec_c   = dif9[DATA_W];
                exec_v   = (a_q[7] != b_q[7]) && (dif9[7] != a_q[7]);
            end
            OpAnd: exec_res = a_q & b_q;
            OpOr:  exec_res = a_q | b_q;
            OpXor: exec_res = a_q ^ b_q;
            OpNot: exec_res = ~a_q;
            OpShl: begin
                exec_res = shl9[DATA_W-1:0];
                exec_c   = shl9[DATA_W];
            end
            OpShr: begin
                exec_res = shr9[DATA_W:1];
                exec_c   = shr9[0];
            end
            // Rotate by n == (a << n) | (a >> (8 - n)); 8 - n taken mod 8
            OpRol: exec_res = (a_q << shamt) | (a_q >> shamt_neg);
            OpRor: exec_res = (a_q >> shamt) | (a_q << shamt_neg);
            OpInc: begin
                exec_res = inc9[DATA_W-1:0];
                exec_c   = inc9[DATA_W];
                exec_v   = (a_q == 8'h7F);
            end
            OpDec: begin
                exec_res = dec9[DATA_W-1:0];
                exec_c   = dec9[DATA_W];
                exec_v   = (a_q == 8'h80);
            end
            // Divide/modulo only reach EXEC when the divisor was zero
            OpDiv, OpMod: begin
                exec_res = 8'hFF;
                exec_err = 1'b1;
            end
            default: begin
                exec_res = 8'h00;
                exec_err = 1'b1;
            end
        endcase

        // CMP reports flags of the subtraction but returns zero
        flag_src = exec_res;
        if (op_q == OpCmp) begin
            exec_res = 8'h00;
        end

        if (exec_err) begin
            exec_stat = 5'h10;
        end else begin
            exec_stat = {1'b0, exec_v, flag_src[7], (flag_src == '0), exec_c};
        end
    end

    // ------------------------------------------------------------------
    // Iterative datapath: one shift-add or restoring-subtract step per cycle
    // ------------------------------------------------------------------
    logic [ProdW-1:0]  prod_next;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   rem_sub;
    logic              div_ge;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] iter_res;
    logic              iter_c;
    logic [STAT_W-1:0] iter_stat;

    // Next partial product / remainder / quotient and the final-step result
    always_comb begin
        prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

        rem_sh  = {rem_q, quo_q[DATA_W-1]};
        // rem_q < divisor keeps rem_sh < 2*divisor, so bit 8 is a clean borrow
        rem_sub = rem_sh - {1'b0, b_q};
        div_ge  = ~rem_sub[DATA_W];
        rem_next = div_ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        quo_next = {quo_q[DATA_W-2:0], div_ge};

        iter_c = 1'b0;
        case (op_q)
            OpMull: begin
                iter_res = prod_next[DATA_W-1:0];
                iter_c   = (prod_next[ProdW-1:DATA_W] != '0);
            end
            OpMulh:  iter_res = prod_next[ProdW-1:DATA_W];
            OpDiv:   iter_res = quo_next;
            default: iter_res = rem_next;
        endcase

        iter_stat = {1'b0, 1'b0, iter_res[7], (iter_res == '0), iter_c};
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    logic start_iter;

    // Multi-cycle ops iterate unless a divide/modulo sees a zero divisor
    always_comb begin
        start_iter = 1'b0;
        if ((alu_bus.alu_op == OpMull) || (alu_bus.alu_op == OpMulh)) begin
            start_iter = 1'b1;
        end else if ((alu_bus.alu_op == OpDiv) || (alu_bus.alu_op == OpMod)) begin
            start_iter = (alu_bus.alu_in2 != '0);
        end
    end

    // Handshake, operand capture, iteration and result write-back
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            out_q    <= '0;
            status_q <= '0;
            ready_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (alu_bus.alu_enable && ready_q) begin
                        op_q     <= alu_bus.alu_op;
                        a_q      <= alu_bus.alu_in1;
                        b_q      <= alu_bus.alu_in2;
                        ready_q  <= 1'b0;
                        cnt_q    <= '0;
                        prod_q   <= '0;
                        mcand_q  <= {{DATA_W{1'b0}}, alu_bus.alu_in1};
                        mplier_q <= alu_bus.alu_in2;
                        rem_q    <= '0;
                        quo_q    <= alu_bus.alu_in1;
                        state_q  <= start_iter ? StIter : StExec;
                    end
                end
                StExec: begin
                    out_q    <= exec_res;
                    status_q <= exec_stat;
                    ready_q  <= 1'b1;
                    state_q  <= StIdle;
                end
                StIter: begin
                    prod_q   <= prod_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    rem_q    <= rem_next;
                    quo_q    <= quo_next;
                    cnt_q    <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        out_q    <= iter_res;
                        status_q <= iter_stat;
                        ready_q  <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: a reference model computes each expected result when a
// request is driven; the entry is popped and compared when ready returns.
module tb_alu_core;

    logic clk;
    logic reset_n;

    alu_if bus ();

    alu_core dut (
        .clk    (clk),
        .reset_n(reset_n),
        .alu_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] out;
        logic [4:0] stat;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] last_out;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model written from the opcode table using integer arithmetic
    function automatic void model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] out, output logic [4:0] stat,
                                  output int lat);
        int ua, ub, sa, sb, r, fr, n, p;
        bit c, v, e;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = int'(b[2:0]);
        r = 0; c = 0; v = 0; e = 0; lat = 1;
        p = ua * ub;
        case (op)
            5'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            5'd1, 5'd12: begin
                r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128);
            end
            5'd2: r = ua & ub;
            5'd3: r = ua | ub;
            5'd4: r = ua ^ ub;
            5'd5: r = 255 - ua;
            5'd6: begin r = ua << n; c = (n != 0) ? a[8-n] : 1'b0; end
            5'd7: begin r = ua >> n; c = (n != 0) ? a[n-1] : 1'b0; end
            5'd8: r = (ua << n) | (ua >> (8 - n));
            5'd9: r = (ua >> n) | (ua << (8 - n));
            5'd10: begin r = ua + 1; c = (ua == 255); v = (sa + 1 > 127); end
            5'd11: begin r = ua - 1; c = (ua == 0); v = (sa - 1 < -128); end
            5'd13: begin r = p % 256; c = (p > 255); lat = 8; end
            5'd14: begin r = p / 256; lat = 8; end
            5'd15, 5'd16: begin
                if (ub == 0) begin
                    r = 255; e = 1;
                end else begin
                    r = (op == 5'd15) ? ua / ub : ua % ub;
                    lat = 8;
                end
            end
            default: begin r = 0; e = 1; end
        endcase
        fr  = r & 255;
        out = (op == 5'd12) ? 8'h00 : fr[7:0];
        if (e) stat = 5'h10;
        else   stat = {1'b0, v, fr[7], (fr[7:0] == 8'h00), c};
    endfunction

    // Drive one request, measure busy time, then check against the scoreboard.
    // With poke set, a second request is strobed mid-operation and must be ignored.
    task automatic send(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit poke);
        exp_t e;
        exp_t got;
        int   lat;
        e.tag = $sformatf("op%0d_%02h_%02h", op, a, b);
        model(op, a, b, e.out, e.stat, e.lat);
        @(negedge clk);
        check_eq({e.tag, "_pre_ready"}, {31'd0, bus.alu_ready}, 32'd1);
        bus.alu_enable = 1'b1;
        bus.alu_op     = op;
        bus.alu_in1    = a;
        bus.alu_in2    = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.alu_enable = 1'b0;
        bus.alu_in1    = ~a;
        bus.alu_in2    = ~b;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.alu_ready) break;
            lat++;
            if (poke && lat == 3) begin
                bus.alu_enable = 1'b1;
                bus.alu_op     = 5'd0;
                bus.alu_in1    = 8'h01;
                bus.alu_in2    = 8'h01;
            end else begin
                bus.alu_enable = 1'b0;
            end
        end
        bus.alu_enable = 1'b0;
        check_eq({e.tag, "_sb_size"}, sb.size(), 32'd1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check_eq({got.tag, "_out"},  {24'd0, bus.alu_out},    {24'd0, got.out});
            check_eq({got.tag, "_stat"}, {27'd0, bus.alu_status}, {27'd0, got.stat});
            check_eq({got.tag, "_lat"},  lat,                     got.lat);
            last_out = got.out;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        bus.alu_enable = 1'b0;
        bus.alu_op     = '0;
        bus.alu_in1    = '0;
        bus.alu_in2    = '0;
        last_out       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ready",  {31'd0, bus.alu_ready},  32'd1);
        check_eq("reset_out",    {24'd0, bus.alu_out},    32'h00);
        check_eq("reset_status", {27'd0, bus.alu_status}, 32'h00);
        reset_n = 1'b1;

        // Directed cases from the plan
        send(5'd0,  8'h7F, 8'h01, 1'b0);
        send(5'd1,  8'h05, 8'h05, 1'b0);
        send(5'd12, 8'h03, 8'h04, 1'b0);
        send(5'd13, 8'h10, 8'h10, 1'b0);
        send(5'd14, 8'h10, 8'h10, 1'b0);
        send(5'd15, 8'd200, 8'd7, 1'b0);
        send(5'd16, 8'd200, 8'd7, 1'b0);
        send(5'd15, 8'h09, 8'h00, 1'b0);
        send(5'd31, 8'h12, 8'h34, 1'b0);

        // Enable strobed while a multiply is busy must not queue
        send(5'd13, 8'h23, 8'h45, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check_eq("poke_idle_ready", {31'd0, bus.alu_ready}, 32'd1);
            check_eq("poke_idle_out",   {24'd0, bus.alu_out},   {24'd0, last_out});
        end

        // Boundaries
        send(5'd10, 8'hFF, 8'h00, 1'b0);
        send(5'd11, 8'h00, 8'h00, 1'b0);
        send(5'd11, 8'h80, 8'h00, 1'b0);
        send(5'd1,  8'h80, 8'h01, 1'b0);
        send(5'd0,  8'hFF, 8'h01, 1'b0);
        send(5'd6,  8'h81, 8'h00, 1'b0);
        send(5'd6,  8'h03, 8'h0F, 1'b0);
        send(5'd7,  8'h0C, 8'h03, 1'b0);
        send(5'd8,  8'h96, 8'h03, 1'b0);
        send(5'd9,  8'h96, 8'h05, 1'b0);
        send(5'd5,  8'hA5, 8'h00, 1'b0);
        send(5'd16, 8'h33, 8'h00, 1'b0);
        send(5'd15, 8'hFF, 8'h01, 1'b0);
        send(5'd14, 8'hFF, 8'hFF, 1'b0);
        send(5'd17, 8'h00, 8'h00, 1'b0);

        // Random mix
        for (int i = 0; i < 40; i++) begin
            logic [4:0] rop;
            logic [7:0] ra;
            logic [7:0] rb;
            rop = 5'($urandom_range(0, 18));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            send(rop, ra, rb, 1'b0);
        end

        // Reset asserted at E+4 of a divide discards it
        @(negedge clk);
        bus.alu_enable = 1'b1;
        bus.alu_op     = 5'd15;
        bus.alu_in1    = 8'd200;
        bus.alu_in2    = 8'd7;
        @(posedge clk);
        #1;
        bus.alu_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midreset_ready",  {31'd0, bus.alu_ready},  32'd1);
        check_eq("midreset_out",    {24'd0, bus.alu_out},    32'h00);
        check_eq("midreset_status", {27'd0, bus.alu_status}, 32'h00);
        reset_n = 1'b1;
        repeat (9) begin
            @(negedge clk);
            check_eq("postreset_out", {24'd0, bus.alu_out}, 32'h00);
        end
        send(5'd0, 8'h01, 8'h01, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Verification-target ALU engine: the responder end of the ALU handshake that the bench drives.
- Accepts an 8-bit operand pair and a 5-bit opcode on an enable/ready handshake.
- Most operations complete in 1 cycle. Multiply, divide and modulo run as 8-cycle iterative shift-add/restoring operations.
- Returns an 8-bit result plus a 5-bit status word, held until the next result.

Parameters:
- DATA_W, 8, operand/result width; only 8 is supported.
- OP_W, 5, opcode width.
- STAT_W, 5, status width.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- alu_enable  input  1  request strobe; sampled only when alu_ready=1.
- alu_in1  input  8  operand A.
- alu_in2  input  8  operand B.
- alu_op  input  5  opcode.
- alu_out  output  8  registered result.
- alu_status  output  5  registered flags: [0] carry, [1] zero, [2] negative, [3] overflow, [4] error.
- alu_ready  output  1  1 = idle and result valid; 0 = busy.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, alu_out=8'h00, alu_status=5'h00, alu_ready=1, iteration counter=0.
  - Reset has priority over everything, including mid-operation; an in-flight operation is discarded and no result is written.
- States: IDLE, EXEC, ITER.
- IDLE:
  - Acceptance edge E: alu_enable=1 while alu_ready=1.
  - At E, capture in1/in2/op, drive alu_ready=0, go to EXEC (single-cycle ops) or ITER (ops 13-16, counter=0).
- EXEC: at edge E+1, write alu_out and alu_status, alu_ready=1, go to IDLE. Ready is low for exactly 1 cycle.
- ITER:
  - One shift-add (MUL) or restoring-subtract (DIV/MOD) step per edge at E+1..E+8.
  - Result is written and alu_ready=1 at E+8. Ready is low for exactly 8 cycles.
- alu_enable while alu_ready=0 is ignored; no queueing.
- alu_out/alu_status hold their last value between results.
- Back-to-back: enable held high is accepted again on the first edge where alu_ready=1 (e.g. E+1 single-cycle → next acceptance at E+2).
- Opcodes (shift amount = in2[2:0]):
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SHL, 7 SHR (logical), 8 ROL, 9 ROR.
  - 10 INC A, 11 DEC A.
  - 12 CMP: flags of A-B, alu_out=8'h00.
  - 13 MULL (low byte of A*B), 14 MULH (high byte), 15 DIV (A/B unsigned), 16 MOD (A%B).
  - 17-31 illegal.
- Flags, legal ops:
  - zero = (result==0), except CMP uses the subtract result.
  - negative = bit7 of that same result.
  - carry:
    - ADD/INC: carry-out.
    - SUB/DEC/CMP: borrow (A<B, or A==0 for DEC).
    - SHL: last bit shifted out of bit7; SHR: last bit shifted out of bit0; shift by 0 → carry=0.
    - MULL: high byte nonzero.
    - All other ops: 0.
  - overflow: signed two's-complement overflow for ADD/SUB/INC/DEC/CMP; else 0.
  - error: 0.
- Illegal opcode: EXEC path (1 cycle), alu_out=8'h00, alu_status=5'h10 (error only).
- DIV/MOD with in2=0:
  - Detected at acceptance, takes the EXEC path (1 cycle), no iteration.
  - alu_out=8'hFF, alu_status=5'h10.
- All arithmetic is on 8-bit unsigned operands. Internal MUL product is 16 bits; internal sums/differences are 9 bits.

Test Plan:
- Reset, then ADD in1=8'h7F in2=8'h01 → at E+1: alu_out=8'h80, alu_status=5'h0C, alu_ready low exactly 1 cycle.
- SUB 8'h05-8'h05 → out=8'h00, status=5'h02. Then CMP 8'h03,8'h04 → out=8'h00, status=5'h05 (borrow, negative).
- MULL 8'h10×8'h10 → ready low 8 cycles, out=8'h00, status=5'h03. MULH same operands → out=8'h01, status=5'h00.
- DIV 8'd200/8'd7 → out=8'h1C at E+8. MOD same operands → out=8'h04. DIV by 0 → out=8'hFF, status=5'h10 at E+1.
- Illegal op 5'd31 → out=8'h00, status=5'h10. Enable pulsed during a MULL busy window is ignored; outputs equal the MULL result only.
- reset_n=0 at E+4 of a DIV → next edge alu_ready=1, out=8'h00, status=5'h00. A new ADD 8'h01+8'h01 then completes with out=8'h02.
